gshare_branch_predictor: RTL and testbench
==========================================

# gshare_branch_predictor

Parametrised next-generation fetch-stage predictor: a tagged, valid-qualified branch target buffer plus a pattern history table of 2-bit saturating counters, indexed either by PC alone (bimodal) or by PC XOR global history (gshare). It keeps a speculative global history register (GHR), snapshots it per prediction, and restores it from the resolving branch on a mispredict. It sits between the IF-stage PC mux and the EX-stage branch resolution.

## Interface
- `INDEX_LENGTH`, 6: log2 of BTB and PHT entry count.
- `GHR_LENGTH`, 6: global history bits; legal range 1..`INDEX_LENGTH`.
- `USE_GSHARE`, 1: 1 hashes the PHT index with the GHR; 0 indexes the PHT by PC only, and the GHR still runs.
- `TAG_LENGTH`, 32-`INDEX_LENGTH`-2: derived, not overridable.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `current_pc` in 32: fetch PC.
- `fetch_valid` in 1: the fetch at `current_pc` advances this cycle (not stalled or flushed).
- `prediction` out 1: predicted taken.
- `predicted_pc` out 32: next fetch PC.
- `pred_ghr` out `GHR_LENGTH`: GHR value used for this prediction; the pipeline carries it to EX.
- `update_valid` in 1: a control-flow instruction resolved in EX this cycle.
- `update_pc` in 32: PC of the resolved instruction.
- `update_taken` in 1: actual outcome.
- `update_target` in 32: actual taken target.
- `update_ghr` in `GHR_LENGTH`: `pred_ghr` carried with that instruction.
- `update_mispredict` in 1: direction or target was wrong; qualified by `update_valid`.

## Operation
- **Index and tag:** BTB index = `pc[INDEX_LENGTH+1:2]`; tag = `pc[31:INDEX_LENGTH+2]`.
- **PHT index:** BTB index XOR {zero-extend GHR} when `USE_GSHARE`=1, else the BTB index.
- **Lookup (combinational):**
  - hit = valid[idx] && tag match.
  - `prediction` = hit && PHT[pidx][1].
  - `predicted_pc` = `prediction` ? BTB target : `current_pc`+4. Addition is 32-bit and wraps modulo 2^32.
- **Counter encoding:** SN=00, WN=01, WT=10, ST=11. Counters saturate; taken increments, not-taken decrements.
- **Update** (`update_valid`=1, committed at the clock edge):
  - The PHT entry at the index computed from `update_pc` and `update_ghr` moves one step toward `update_taken`. This happens whether or not the BTB hits.
  - If `update_taken`=1, the BTB entry at `update_pc`'s index gets valid=1, the new tag and `update_target`. This overwrites any conflicting entry.
  - If `update_taken`=0, the BTB is unchanged.
- **Speculative GHR:**
  - If `fetch_valid` && hit: GHR <= {GHR[`GHR_LENGTH`-2:0], `prediction`}.
  - Fetches that miss the BTB do not shift the GHR.
- **Recovery:**
  - If `update_valid` && `update_mispredict`: GHR <= {`update_ghr`[`GHR_LENGTH`-2:0], `update_taken`}.
  - Recovery overrides a same-cycle fetch shift.
  - When `GHR_LENGTH`=1, the shift yields just the new bit.
- **Reset:**
  - All valid bits cleared; all counters set to WN; GHR cleared to 0.
  - BTB targets and tags are not reset.
  - Outputs after reset: `prediction`=0, `predicted_pc`=`current_pc`+4, `pred_ghr`=0.
  - Reset overrides any same-cycle update or shift.

## Timing
- Prediction has zero latency: outputs are combinational from `current_pc` and state.
- Updates become visible to lookups on the cycle after the edge.
- Same-cycle lookup and update of one entry: the lookup sees the pre-update value. There is no bypass.
- `pred_ghr` reflects the GHR before that cycle's shift.
- Reset asserted mid-stream takes effect at the next edge. Any in-flight `update_ghr` values arriving later are still honoured.

## Structure
- Package `bp_pkg`: counter encodings (SN/WN/WT/ST) and a `sat_step(counter, taken)` function.
- Sub-module `bp_btb`: valid/tag/target arrays with a combinational read port and a synchronous write port, parametrised by `INDEX_LENGTH`.
- PHT, GHR and index hashing live in the top level.

## Test plan
- **Reset:** reset with `current_pc`=0x100 -> `prediction`=0, `predicted_pc`=0x104, `pred_ghr`=0.
- **Training:**
  - Update `pc`=0x40 taken, target 0x80, `update_ghr`=0, twice (`USE_GSHARE`=0). Then fetch 0x40 -> counter ST, `prediction`=1, `predicted_pc`=0x80.
  - After one not-taken update -> WT, still predicts 0x80.
- **Aliasing:** with `INDEX_LENGTH`=4, train 0x40 taken, then train 0x80 taken to target 0xC0 -> lookup of 0x40 misses (tag replaced) and predicts 0x44.
- **Gshare separation:** same PC 0x40 trained taken under GHR=0b000001 and not-taken under GHR=0b000010 -> each GHR context predicts its own direction.
- **Recovery priority:** fetch hit with `fetch_valid`=1 in the same cycle as a mispredict with `update_ghr`=0b101010 and `update_taken`=0 (`GHR_LENGTH`=6) -> next `pred_ghr`=0b010100.
- **Wrap and read-during-write:**
  - Fetch 0xFFFFFFFC with no hit -> `predicted_pc`=0x00000000.
  - Lookup and update of the same entry in one cycle -> old prediction that cycle, new prediction the next.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor.
// ctr_e    : 2-bit saturating direction counter (SN/WN/WT/ST).
// sat_step : moves a counter one step toward the resolved direction.
package bp_pkg;

  typedef enum logic [1:0] {
    SN = 2'b00,
    WN = 2'b01,
    WT = 2'b10,
    ST = 2'b11
  } ctr_e;

  function automatic ctr_e sat_step(input ctr_e ctr, input logic taken);
    ctr_e res;
    res = ctr;
    if (taken) begin
      if (ctr != ST) res = ctr_e'(ctr + 2'd1);
    end else begin
      if (ctr != SN) res = ctr_e'(ctr - 2'd1);
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Branch target buffer: direct-mapped valid/tag/target arrays.
// clk, reset                   : clock and synchronous active-high reset (clears valid bits only)
// rd_idx_i                     : combinational read index
// rd_valid_o/rd_tag_o/rd_target_o : read data for rd_idx_i
// wr_en_i/wr_idx_i/wr_tag_i/wr_target_i : synchronous write port, sets valid
module bp_btb #(
  parameter int  INDEX_LENGTH = 6,
  localparam int TAG_LENGTH   = 32 - INDEX_LENGTH - 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [INDEX_LENGTH-1:0] rd_idx_i,
  output logic                    rd_valid_o,
  output logic [TAG_LENGTH-1:0]   rd_tag_o,
  output logic [31:0]             rd_target_o,
  input  logic                    wr_en_i,
  input  logic [INDEX_LENGTH-1:0] wr_idx_i,
  input  logic [TAG_LENGTH-1:0]   wr_tag_i,
  input  logic [31:0]             wr_target_i
);

  localparam int ENTRIES = 1 << INDEX_LENGTH;

  logic                  valid_q  [ENTRIES];
  logic [TAG_LENGTH-1:0] tag_q    [ENTRIES];
  logic [31:0]           target_q [ENTRIES];

  assign rd_valid_o  = valid_q[rd_idx_i];
  assign rd_tag_o    = tag_q[rd_idx_i];
  assign rd_target_o = target_q[rd_idx_i];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tags and targets carry no reset; a cleared valid bit masks them.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]    <= wr_tag_i;
      target_q[wr_idx_i] <= wr_target_i;
    end
  end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Fetch-stage direction/target predictor: BTB + PHT of 2-bit counters,
// indexed by PC or PC^GHR, with a speculative global history register.
// current_pc/fetch_valid           : fetch lookup and GHR-advance qualifier
// prediction/predicted_pc/pred_ghr : combinational lookup result and history snapshot
// update_*                         : EX-stage resolution; mispredict restores the GHR
module gshare_branch_predictor
  import bp_pkg::*;
#(
  parameter int  INDEX_LENGTH = 6,
  parameter int  GHR_LENGTH   = 6,
  parameter bit  USE_GSHARE   = 1'b1,
  localparam int TAG_LENGTH   = 32 - INDEX_LENGTH - 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           current_pc,
  input  logic                  fetch_valid,
  output logic                  prediction,
  output logic [31:0]           predicted_pc,
  output logic [GHR_LENGTH-1:0] pred_ghr,
  input  logic                  update_valid,
  input  logic [31:0]           update_pc,
  input  logic                  update_taken,
  input  logic [31:0]           update_target,
  input  logic [GHR_LENGTH-1:0] update_ghr,
  input  logic                  update_mispredict
);

  localparam int ENTRIES = 1 << INDEX_LENGTH;

  logic [GHR_LENGTH-1:0]   ghr_q, ghr_d;
  ctr_e                    pht_q [ENTRIES];

  logic [INDEX_LENGTH-1:0] fetch_idx, upd_idx, fetch_pidx, upd_pidx;
  logic                    btb_valid, hit;
  logic [TAG_LENGTH-1:0]   btb_tag;
  logic [31:0]             btb_target;
  logic [GHR_LENGTH-1:0]   fetch_shift, recover_shift;
  logic                    unused_bits;

  assign unused_bits = ^{update_pc[1:0], update_ghr};

  assign fetch_idx  = current_pc[INDEX_LENGTH+1:2];
  assign upd_idx    = update_pc[INDEX_LENGTH+1:2];
  assign fetch_pidx = USE_GSHARE ? (fetch_idx ^ INDEX_LENGTH'(ghr_q)) : fetch_idx;
  assign upd_pidx   = USE_GSHARE ? (upd_idx ^ INDEX_LENGTH'(update_ghr)) : upd_idx;

  bp_btb #(
    .INDEX_LENGTH(INDEX_LENGTH)
  ) u_btb (
    .clk        (clk),
    .reset      (reset),
    .rd_idx_i   (fetch_idx),
    .rd_valid_o (btb_valid),
    .rd_tag_o   (btb_tag),
    .rd_target_o(btb_target),
    .wr_en_i    (update_valid && update_taken && !reset),
    .wr_idx_i   (upd_idx),
    .wr_tag_i   (update_pc[31:INDEX_LENGTH+2]),
    .wr_target_i(update_target)
  );

  assign hit          = btb_valid && (btb_tag == current_pc[31:INDEX_LENGTH+2]);
  assign prediction   = hit && pht_q[fetch_pidx][1];
  assign predicted_pc = prediction ? btb_target : current_pc + 32'd4;
  assign pred_ghr     = ghr_q;

  // A one-bit history has no older bits to keep.
  if (GHR_LENGTH == 1) begin : g_ghr1
    assign fetch_shift   = prediction;
    assign recover_shift = update_taken;
  end else begin : g_ghrn
    assign fetch_shift   = {ghr_q[GHR_LENGTH-2:0], prediction};
    assign recover_shift = {update_ghr[GHR_LENGTH-2:0], update_taken};
  end

  // Recovery from EX outranks the speculative shift of the current fetch.
  always_comb begin
    ghr_d = ghr_q;
    if (update_valid && update_mispredict) ghr_d = recover_shift;
    else if (fetch_valid && hit)           ghr_d = fetch_shift;
  end

  always_ff @(posedge clk) begin
    if (reset) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) pht_q[i] <= WN;
    end else if (update_valid) begin
      pht_q[upd_pidx] <= sat_step(pht_q[upd_pidx], update_taken);
    end
  end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
module tb_gshare_branch_predictor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, fetch_valid, update_valid, update_taken, update_mispredict;
  logic [31:0] current_pc, update_pc, update_target;
  logic [5:0]  ughr;
  logic [3:0]  ughr_bm;
  assign ughr_bm = ughr[3:0];

  logic        pred_gs, pred_bm;
  logic [31:0] ppc_gs, ppc_bm;
  logic [5:0]  pg_gs;
  logic [3:0]  pg_bm;

  // instance 0: gshare, 64 entries, 6-bit history
  gshare_branch_predictor #(.INDEX_LENGTH(6), .GHR_LENGTH(6), .USE_GSHARE(1'b1)) u_gs (
    .clk(clk), .reset(reset), .current_pc(current_pc), .fetch_valid(fetch_valid),
    .prediction(pred_gs), .predicted_pc(ppc_gs), .pred_ghr(pg_gs),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_ghr(ughr), .update_mispredict(update_mispredict));

  // instance 1: bimodal, 16 entries, 4-bit history
  gshare_branch_predictor #(.INDEX_LENGTH(4), .GHR_LENGTH(4), .USE_GSHARE(1'b0)) u_bm (
    .clk(clk), .reset(reset), .current_pc(current_pc), .fetch_valid(fetch_valid),
    .prediction(pred_bm), .predicted_pc(ppc_bm), .pred_ghr(pg_bm),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_ghr(ughr_bm), .update_mispredict(update_mispredict));

  int checks = 0;
  int errors = 0;

  // Reference model: per-instance tables addressed with plain arithmetic.
  bit          m_valid [2][64];
  int unsigned m_tag   [2][64];
  int unsigned m_tgt   [2][64];
  int          m_pht   [2][64];
  int unsigned m_ghr   [2];

  function automatic int unsigned f_il(int k); return (k == 0) ? 6 : 4; endfunction
  function automatic int unsigned f_gmask(int k); return (k == 0) ? 63 : 15; endfunction
  function automatic int unsigned f_idx(int k, int unsigned pc);
    return (pc >> 2) % (1 << f_il(k));
  endfunction
  function automatic int unsigned f_pidx(int k, int unsigned pc, int unsigned gh);
    return (k == 0) ? (f_idx(k, pc) ^ (gh & f_gmask(k))) : f_idx(k, pc);
  endfunction

  task automatic m_lookup(input int k, output bit hit, output bit pred, output int unsigned ppc);
    int unsigned pc, i;
    pc   = current_pc;
    i    = f_idx(k, pc);
    hit  = m_valid[k][i] && (m_tag[k][i] == (pc >> (f_il(k) + 2)));
    pred = hit && (m_pht[k][f_pidx(k, pc, m_ghr[k])] >= 2);
    ppc  = pred ? m_tgt[k][i] : pc + 32'd4;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait for the mid-cycle sample point and compare every output to the model.
  task automatic look(input bit do_chk);
    bit hit, pred;
    int unsigned ppc;
    @(negedge clk);
    if (do_chk) begin
      for (int k = 0; k < 2; k++) begin
        m_lookup(k, hit, pred, ppc);
        chk($sformatf("k%0d_pred@%0t", k, $time), (k == 0) ? {31'b0, pred_gs} : {31'b0, pred_bm}, {31'b0, pred});
        chk($sformatf("k%0d_ppc@%0t", k, $time), (k == 0) ? ppc_gs : ppc_bm, ppc);
        chk($sformatf("k%0d_ghr@%0t", k, $time), (k == 0) ? {26'b0, pg_gs} : {28'b0, pg_bm}, m_ghr[k]);
      end
    end
  endtask

  // Advance the model with this cycle's inputs, then let the clock edge happen.
  task automatic commit();
    bit hit, pred;
    int unsigned ppc, p, i, gh;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        for (int e = 0; e < 64; e++) begin
          m_valid[k][e] = 1'b0;
          m_pht[k][e]   = 1;
        end
        m_ghr[k] = 0;
      end else begin
        m_lookup(k, hit, pred, ppc);
        gh = int'(ughr) & f_gmask(k);
        if (update_valid) begin
          p = f_pidx(k, update_pc, gh);
          if (update_taken) m_pht[k][p] = (m_pht[k][p] == 3) ? 3 : m_pht[k][p] + 1;
          else              m_pht[k][p] = (m_pht[k][p] == 0) ? 0 : m_pht[k][p] - 1;
          if (update_taken) begin
            i = f_idx(k, update_pc);
            m_valid[k][i] = 1'b1;
            m_tag[k][i]   = update_pc >> (f_il(k) + 2);
            m_tgt[k][i]   = update_target;
          end
        end
        if (update_valid && update_mispredict)
          m_ghr[k] = ((gh << 1) | int'(update_taken)) & f_gmask(k);
        else if (fetch_valid && hit)
          m_ghr[k] = ((m_ghr[k] << 1) | int'(pred)) & f_gmask(k);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; fetch_valid = 1'b0; update_valid = 1'b0; update_taken = 1'b0;
    update_mispredict = 1'b0; update_pc = 32'h0; update_target = 32'h0; ughr = 6'd0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic [5:0] gh, input logic mis);
    update_valid = 1'b1; update_pc = pc; update_taken = tk; update_target = tgt;
    ughr = gh; update_mispredict = mis;
  endtask

  logic [31:0] pool [8];

  initial begin
    pool = '{32'h40, 32'h80, 32'hC0, 32'h100, 32'h140, 32'h500, 32'hFFFF_FFFC, 32'h1040};
    idle_inputs();
    reset = 1'b1; current_pc = 32'h100;
    look(0); commit();
    look(0); commit();

    // reset state
    reset = 1'b0;
    look(1);
    chk("rst_pred_gs", {31'b0, pred_gs}, 32'd0);
    chk("rst_ppc_gs", ppc_gs, 32'h104);
    chk("rst_ghr_gs", {26'b0, pg_gs}, 32'd0);
    chk("rst_ppc_bm", ppc_bm, 32'h104);
    commit();

    // training: two taken updates -> ST
    current_pc = 32'h200;
    upd(32'h40, 1'b1, 32'h80, 6'd0, 1'b0); look(1); commit();
    look(1); commit();
    idle_inputs(); current_pc = 32'h40;
    look(1);
    chk("train_pred_bm", {31'b0, pred_bm}, 32'd1);
    chk("train_ppc_bm", ppc_bm, 32'h80);
    chk("train_ppc_gs", ppc_gs, 32'h80);
    commit();

    // one not-taken -> WT, still taken
    upd(32'h40, 1'b0, 32'h0, 6'd0, 1'b0); look(1); commit();
    idle_inputs();
    look(1);
    chk("wt_ppc_bm", ppc_bm, 32'h80);
    chk("wt_ppc_gs", ppc_gs, 32'h80);
    commit();

    // aliasing in the 16-entry instance
    upd(32'h80, 1'b1, 32'hC0, 6'd0, 1'b0); look(1); commit();
    idle_inputs(); current_pc = 32'h40;
    look(1);
    chk("alias_ppc_bm", ppc_bm, 32'h44);
    chk("alias_ppc_gs", ppc_gs, 32'h80);
    commit();

    // gshare separation: taken under GHR=1, not-taken under GHR=2
    upd(32'h40, 1'b1, 32'h80, 6'd1, 1'b0); look(1); commit();
    look(1); commit();
    upd(32'h40, 1'b0, 32'h0, 6'd2, 1'b0); look(1); commit();
    look(1); commit();
    upd(32'h40, 1'b1, 32'h80, 6'd0, 1'b1); look(1); commit();
    idle_inputs();
    look(1);
    chk("gs_ctx1_ghr", {26'b0, pg_gs}, 32'd1);
    chk("gs_ctx1_pred", {31'b0, pred_gs}, 32'd1);
    chk("gs_ctx1_ppc", ppc_gs, 32'h80);
    commit();
    upd(32'h40, 1'b0, 32'h0, 6'd1, 1'b1); look(1); commit();
    idle_inputs();
    look(1);
    chk("gs_ctx2_ghr", {26'b0, pg_gs}, 32'd2);
    chk("gs_ctx2_pred", {31'b0, pred_gs}, 32'd0);
    chk("gs_ctx2_ppc", ppc_gs, 32'h44);
    commit();

    // recovery outranks a same-cycle fetch shift
    fetch_valid = 1'b1;
    upd(32'h300, 1'b0, 32'h0, 6'b101010, 1'b1); look(1); commit();
    idle_inputs();
    look(1);
    chk("recover_ghr_gs", {26'b0, pg_gs}, 32'b010100);
    commit();

    // PC+4 wraps
    current_pc = 32'hFFFF_FFFC;
    look(1);
    chk("wrap_ppc_gs", ppc_gs, 32'h0);
    chk("wrap_ppc_bm", ppc_bm, 32'h0);
    commit();

    // read-during-write: old value this cycle, new value next
    current_pc = 32'h500;
    upd(32'h500, 1'b1, 32'h600, 6'b010100, 1'b0);
    look(1);
    chk("rdw_old_pred_gs", {31'b0, pred_gs}, 32'd0);
    chk("rdw_old_ppc_gs", ppc_gs, 32'h504);
    commit();
    idle_inputs();
    look(1);
    chk("rdw_new_pred_gs", {31'b0, pred_gs}, 32'd1);
    chk("rdw_new_ppc_gs", ppc_gs, 32'h600);
    commit();

    // randomized traffic against the model, with occasional mid-stream reset
    for (int n = 0; n < 400; n++) begin
      reset             = ($urandom_range(0, 49) == 0);
      current_pc        = pool[$urandom_range(0, 7)];
      fetch_valid       = 1'($urandom_range(0, 1));
      update_valid      = ($urandom_range(0, 2) != 0);
      update_pc         = pool[$urandom_range(0, 7)];
      update_taken      = 1'($urandom_range(0, 1));
      update_target     = $urandom & 32'hFFFF_FFFC;
      ughr              = ($urandom_range(0, 1) == 1) ? 6'(m_ghr[0]) : 6'($urandom_range(0, 63));
      update_mispredict = ($urandom_range(0, 3) == 0);
      look(1);
      commit();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
